card_match_judge: RTL and testbench
===================================

CARD_MATCH_JUDGE -- requirements
Module: card_match_judge

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 50_000_000, number of cycles a mismatched pair stays face-up (minimum 1).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port load  input  1  one-cycle pulse; latch map and start a new game.
REQ-005 SHALL have port map  input  [0:47]  card values; card i value = map[3*i +: 3], i = 0..15.
REQ-006 SHALL have port pick  input  1  one-cycle pulse; player selects a card.
REQ-007 SHALL have port pick_idx  input  4  index of the selected card; sampled only when pick = 1.
REQ-008 SHALL have port revealed  output  16  bit i = 1 while card i is face-up and unmatched.
REQ-009 SHALL have port matched  output  16  bit i = 1 once card i belongs to a matched pair.
REQ-010 SHALL have port result_valid  output  1  one-cycle pulse when a pair has been judged.
REQ-011 SHALL have port result_match  output  1  judgement of the last pair; 1 = values equal; held until next judgement.
REQ-012 SHALL have port pairs_found  output  4  matched pair count, 0..8.
REQ-013 SHALL have port busy  output  1  high in COMPARE and HOLD.
REQ-014 SHALL have port game_done  output  1  level; high in OVER.

Function
REQ-015 SHALL implement states IDLE, WAIT1, WAIT2, COMPARE, HOLD, OVER.
REQ-016 On load in any state: map SHALL be latched into an internal register; revealed, matched, pairs_found and result_match SHALL clear; state SHALL go to WAIT1.
REQ-017 load SHALL take priority over a pick in the same cycle; that pick SHALL be ignored.
REQ-018 Picks SHALL be accepted only in WAIT1/WAIT2 and only if pick_idx is neither revealed nor matched; all other picks SHALL be ignored with no state change.
REQ-019 On an accepted pick in WAIT1: at that edge, revealed[pick_idx] SHALL be set, pick_idx stored as card A, and state SHALL go to WAIT2.
REQ-020 On an accepted pick in WAIT2: at that edge, revealed[pick_idx] SHALL be set, pick_idx stored as card B, and state SHALL go to COMPARE.
REQ-021 COMPARE SHALL last exactly one cycle; at its exit edge result_valid SHALL be driven to 1 for one cycle and result_match to (value A == value B).
REQ-022 On a match: at the same edge, matched[A] and matched[B] SHALL be set, revealed[A] and revealed[B] cleared, and pairs_found incremented; next state SHALL be OVER if pairs_found becomes 8, else WAIT1.
REQ-023 On a mismatch: next state SHALL be HOLD, with the hold counter loaded.
REQ-024 HOLD SHALL last exactly HOLD_CYCLES cycles; at its exit edge revealed[A] and revealed[B] SHALL clear and state SHALL go to WAIT1.
REQ-025 Result timing: if the second pick is accepted at edge t, result_valid SHALL be high in the cycle after edge t+1.
REQ-026 Value comparison SHALL be 3-bit unsigned equality on the latched map only; changes on the map input after load SHALL have no effect.
REQ-027 OVER SHALL hold, with game_done = 1, until load or reset.
REQ-028 Outputs SHALL all be registered.

Reset
REQ-029 On reset, state SHALL be IDLE and revealed, matched, result_valid, result_match, pairs_found, busy, game_done, the map register and the hold counter SHALL all be 0.
REQ-030 Reset mid-HOLD or mid-game SHALL abandon the game; picks SHALL be ignored until the next load.

Structure
REQ-031 NUM_CARDS = 16, CARD_W = 3, NUM_PAIRS = 8 and the state encodings SHALL reside in the shared card_flip_defs constants file.
REQ-032 The HOLD countdown SHALL be a sub-module, hold_timer (inputs: load strobe and HOLD_CYCLES; output: expire pulse).

Verification
Test conditions: HOLD_CYCLES = 4; map with card i value = i>>1.
REQ-033 Match: load, pick 0, then pick 1 -> result_valid pulse with result_match = 1; matched = 16'h0003; pairs_found = 1; revealed = 0.
REQ-034 Mismatch: load, pick 0, then pick 2 -> result_match = 0; revealed = 16'h0005 for exactly 4 HOLD cycles, then 0; state back to WAIT1.
REQ-035 Illegal picks: re-pick 0 while revealed, a pick during HOLD, and pick of a matched card -> all ignored; no result_valid.
REQ-036 Full game: 8 matching pairs -> pairs_found = 8, matched = 16'hFFFF, game_done = 1; further picks ignored.
REQ-037 Priority/reset: load together with pick -> pick ignored, state WAIT1; reset during HOLD -> all outputs 0, state IDLE, picks ignored until load.

Source files
------------

// File: rtl/card_flip_defs.sv
// Shared constants, state encoding and card-value lookup for the card matching game.
`default_nettype none

package card_flip_defs;

  localparam int NUM_CARDS = 16;
  localparam int CARD_W    = 3;
  localparam int NUM_PAIRS = 8;
  localparam int MAP_W     = NUM_CARDS * CARD_W;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT1   = 3'd1,
    ST_WAIT2   = 3'd2,
    ST_COMPARE = 3'd3,
    ST_HOLD    = 3'd4,
    ST_OVER    = 3'd5
  } state_t;

  // Card 0 occupies the lowest-numbered bits of the ascending map vector.
  function automatic logic [CARD_W-1:0] card_value(input logic [0:MAP_W-1] m,
                                                   input logic [3:0] idx);
    return m[CARD_W*idx +: CARD_W];
  endfunction

endpackage

`default_nettype wire

// File: rtl/hold_timer.sv
// Countdown for the face-up hold of a mismatched pair; expire is high in the last hold cycle.
`default_nettype none

module hold_timer #(
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic abort,
  output logic expire
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  logic [CNT_W-1:0] count;
  logic             active;

  always_ff @(posedge clk) begin
    if (reset || abort) begin
      count  <= '0;
      active <= 1'b0;
    end else if (start) begin
      count  <= CNT_W'(HOLD_CYCLES - 1);
      active <= 1'b1;
    end else if (active) begin
      if (count == '0) active <= 1'b0;
      else             count  <= count - CNT_W'(1);
    end
  end

  assign expire = active && (count == '0);

endmodule

`default_nettype wire

// File: rtl/card_match_judge.sv
// Memory-game referee: tracks two picks per turn, judges the pair and keeps the score.
`default_nettype none

module card_match_judge
  import card_flip_defs::*;
#(
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [0:47]       map,
  input  logic              pick,
  input  logic [3:0]        pick_idx,
  output logic [15:0]       revealed,
  output logic [15:0]       matched,
  output logic              result_valid,
  output logic              result_match,
  output logic [3:0]        pairs_found,
  output logic              busy,
  output logic              game_done
);

  state_t             state, state_next;
  logic [0:MAP_W-1]   map_q;
  logic [3:0]         card_a, card_b;
  logic               accept, is_match, expire, start_hold;
  logic               busy_next, done_next;

  assign accept = pick && !load && (state == ST_WAIT1 || state == ST_WAIT2)
                  && !revealed[pick_idx] && !matched[pick_idx];
  assign is_match   = card_value(map_q, card_a) == card_value(map_q, card_b);
  assign start_hold = (state == ST_COMPARE) && !is_match && !load;

  hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (start_hold),
    .abort  (load),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_WAIT1:   if (accept) state_next = ST_WAIT2;
      ST_WAIT2:   if (accept) state_next = ST_COMPARE;
      ST_COMPARE: begin
        if (!is_match)                             state_next = ST_HOLD;
        else if (pairs_found == 4'(NUM_PAIRS - 1)) state_next = ST_OVER;
        else                                       state_next = ST_WAIT1;
      end
      ST_HOLD:    if (expire) state_next = ST_WAIT1;
      default:    state_next = state;
    endcase
    if (load) state_next = ST_WAIT1;
  end

  always_comb begin
    busy_next = (state_next == ST_COMPARE) || (state_next == ST_HOLD);
    done_next = (state_next == ST_OVER);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      map_q        <= '0;
      revealed     <= '0;
      matched      <= '0;
      pairs_found  <= '0;
      result_valid <= 1'b0;
      result_match <= 1'b0;
      card_a       <= '0;
      card_b       <= '0;
      busy         <= 1'b0;
      game_done    <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      busy         <= busy_next;
      game_done    <= done_next;
      if (load) begin
        map_q        <= map;
        revealed     <= '0;
        matched      <= '0;
        pairs_found  <= '0;
        result_match <= 1'b0;
      end else if (accept) begin
        revealed[pick_idx] <= 1'b1;
        if (state == ST_WAIT1) card_a <= pick_idx;
        else                   card_b <= pick_idx;
      end else if (state == ST_COMPARE) begin
        result_valid <= 1'b1;
        result_match <= is_match;
        if (is_match) begin
          matched[card_a]  <= 1'b1;
          matched[card_b]  <= 1'b1;
          revealed[card_a] <= 1'b0;
          revealed[card_b] <= 1'b0;
          pairs_found      <= pairs_found + 4'd1;
        end
      end else if (state == ST_HOLD && expire) begin
        revealed[card_a] <= 1'b0;
        revealed[card_b] <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_card_match_judge.sv
// Directed bench for card_match_judge with HOLD_CYCLES = 4 and card i value = i>>1.
`default_nettype none

module tb_card_match_judge;

  logic        clk = 1'b0;
  logic        reset, load, pick;
  logic [0:47] map;
  logic [3:0]  pick_idx;
  logic [15:0] revealed, matched;
  logic        result_valid, result_match, busy, game_done;
  logic [3:0]  pairs_found;

  int tests = 0;
  int fails = 0;

  card_match_judge #(.HOLD_CYCLES(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .load         (load),
    .map          (map),
    .pick         (pick),
    .pick_idx     (pick_idx),
    .revealed     (revealed),
    .matched      (matched),
    .result_valid (result_valid),
    .result_match (result_match),
    .pairs_found  (pairs_found),
    .busy         (busy),
    .game_done    (game_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_pick(input logic [3:0] idx);
    pick = 1'b1;
    pick_idx = idx;
    tick();
    pick = 1'b0;
  endtask

  task automatic do_load();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic play_pair(input logic [3:0] a, input logic [3:0] b);
    do_pick(a);
    do_pick(b);
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".revealed"}, 32'(revealed), 32'h0);
    check({tag, ".matched"}, 32'(matched), 32'h0);
    check({tag, ".result_valid"}, 32'(result_valid), 32'h0);
    check({tag, ".result_match"}, 32'(result_match), 32'h0);
    check({tag, ".pairs_found"}, 32'(pairs_found), 32'h0);
    check({tag, ".busy"}, 32'(busy), 32'h0);
    check({tag, ".game_done"}, 32'(game_done), 32'h0);
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; pick = 1'b0; pick_idx = '0;
    for (int i = 0; i < 16; i++) map[3*i +: 3] = 3'(i >> 1);
    tick(2);
    reset = 1'b0;
    check_all_zero("reset");

    // IDLE ignores picks before any load
    do_pick(4'd0);
    check("idle_pick.revealed", 32'(revealed), 32'h0);

    // Matching pair 0/1
    do_load();
    check("load.revealed", 32'(revealed), 32'h0);
    do_pick(4'd0);
    check("pickA.revealed", 32'(revealed), 32'h0001);
    check("pickA.busy", 32'(busy), 32'h0);
    do_pick(4'd1);
    check("pickB.revealed", 32'(revealed), 32'h0003);
    check("pickB.busy", 32'(busy), 32'h1);
    check("pickB.result_valid", 32'(result_valid), 32'h0);
    tick();
    check("match.result_valid", 32'(result_valid), 32'h1);
    check("match.result_match", 32'(result_match), 32'h1);
    check("match.matched", 32'(matched), 32'h0003);
    check("match.revealed", 32'(revealed), 32'h0);
    check("match.pairs_found", 32'(pairs_found), 32'h1);
    check("match.busy", 32'(busy), 32'h0);
    tick();
    check("match.rv_pulse", 32'(result_valid), 32'h0);
    check("match.rm_held", 32'(result_match), 32'h1);

    // Mismatch 2 (value 1) vs 4 (value 2), with a pick during HOLD
    do_pick(4'd2);
    do_pick(4'd4);
    tick();
    check("mis.result_valid", 32'(result_valid), 32'h1);
    check("mis.result_match", 32'(result_match), 32'h0);
    check("mis.hold1.revealed", 32'(revealed), 32'h0014);
    check("mis.hold1.busy", 32'(busy), 32'h1);
    do_pick(4'd6);
    check("mis.hold2.revealed", 32'(revealed), 32'h0014);
    check("mis.hold2.result_valid", 32'(result_valid), 32'h0);
    tick(2);
    check("mis.hold4.revealed", 32'(revealed), 32'h0014);
    check("mis.hold4.busy", 32'(busy), 32'h1);
    tick();
    check("mis.exit.revealed", 32'(revealed), 32'h0);
    check("mis.exit.busy", 32'(busy), 32'h0);
    check("mis.exit.result_valid", 32'(result_valid), 32'h0);

    // Illegal picks: re-pick a revealed card and pick a matched card
    do_pick(4'd6);
    check("ill.first.revealed", 32'(revealed), 32'h0040);
    do_pick(4'd6);
    check("ill.repick.revealed", 32'(revealed), 32'h0040);
    check("ill.repick.busy", 32'(busy), 32'h0);
    do_pick(4'd0);
    check("ill.matched.revealed", 32'(revealed), 32'h0040);
    check("ill.matched.busy", 32'(busy), 32'h0);
    check("ill.result_valid", 32'(result_valid), 32'h0);
    do_pick(4'd7);
    tick();
    check("pair67.result_match", 32'(result_match), 32'h1);
    check("pair67.matched", 32'(matched), 32'h00C3);
    check("pair67.pairs_found", 32'(pairs_found), 32'h2);

    // Map input changed after load must not alter judgement: 3 vs 5 still differ
    map = '0;
    do_pick(4'd3);
    do_pick(4'd5);
    tick();
    check("latched.result_valid", 32'(result_valid), 32'h1);
    check("latched.result_match", 32'(result_match), 32'h0);
    tick(4);
    check("latched.revealed", 32'(revealed), 32'h0);

    // Finish the game
    play_pair(4'd2, 4'd3);
    play_pair(4'd4, 4'd5);
    play_pair(4'd8, 4'd9);
    play_pair(4'd10, 4'd11);
    play_pair(4'd12, 4'd13);
    check("game.pairs_mid", 32'(pairs_found), 32'h7);
    check("game.done_mid", 32'(game_done), 32'h0);
    play_pair(4'd15, 4'd14);
    check("game.pairs_found", 32'(pairs_found), 32'h8);
    check("game.matched", 32'(matched), 32'hFFFF);
    check("game.game_done", 32'(game_done), 32'h1);
    check("game.busy", 32'(busy), 32'h0);
    do_pick(4'd0);
    do_pick(4'd1);
    tick();
    check("over.revealed", 32'(revealed), 32'h0);
    check("over.result_valid", 32'(result_valid), 32'h0);
    check("over.game_done", 32'(game_done), 32'h1);

    // Load wins over a simultaneous pick
    for (int i = 0; i < 16; i++) map[3*i +: 3] = 3'(i >> 1);
    load = 1'b1; pick = 1'b1; pick_idx = 4'd3;
    tick();
    load = 1'b0; pick = 1'b0;
    check("prio.revealed", 32'(revealed), 32'h0);
    check("prio.matched", 32'(matched), 32'h0);
    check("prio.pairs_found", 32'(pairs_found), 32'h0);
    check("prio.game_done", 32'(game_done), 32'h0);
    do_pick(4'd0);
    check("prio.wait1.revealed", 32'(revealed), 32'h0001);

    // Reset during HOLD abandons the game
    do_pick(4'd2);
    tick(2);
    check("rst.in_hold.busy", 32'(busy), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("rst");
    do_pick(4'd0);
    check("rst.pick_ignored", 32'(revealed), 32'h0);
    tick(6);
    check("rst.still_idle", 32'(busy), 32'h0);
    do_load();
    do_pick(4'd0);
    check("rst.reload.revealed", 32'(revealed), 32'h0001);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
